// File: rtl/bp_pkg.sv
// bp_pkg -- shared types and constants for the branch-predictor update path.
//   upd_entry_t : one queued execute-stage update {pc, ta, pcsrc, we_pb, we_ta}
//   bp_state_t  : update-controller FSM state (IDLE / SWEEP)
//   PRD_BITS    : byte-offset bits below the predictor index in a PC
package bp_pkg;

    localparam int PRD_BITS = 2;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] ta;
        logic        pcsrc;
        logic        we_pb;
        logic        we_ta;
    } upd_entry_t;

    typedef enum logic {
        IDLE  = 1'b0,
        SWEEP = 1'b1
    } bp_state_t;

endpackage

// File: rtl/bp_upd_fifo.sv
// bp_upd_fifo -- small synchronous FIFO holding pending predictor updates.
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   clr             synchronous clear (empties the FIFO; wins over write/read)
//   wr_en, din      push request and data (ignored when full)
//   rd_en           pop request (ignored when empty)
//   dout            head entry, valid whenever !empty
//   count           number of stored entries (0..QDEPTH)
//   full, empty     status derived from count
// QDEPTH must be a power of two >= 2 so the pointers wrap naturally.
module bp_upd_fifo
    import bp_pkg::*;
#(
    parameter int  QDEPTH  = 2,
    parameter type entry_t = upd_entry_t
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clr,
    input  logic                     wr_en,
    input  logic                     rd_en,
    input  entry_t                   din,
    output entry_t                   dout,
    output logic [$clog2(QDEPTH):0]  count,
    output logic                     full,
    output logic                     empty
);

    localparam int PW = $clog2(QDEPTH);
    localparam int CW = PW + 1;

    entry_t          mem [QDEPTH];
    logic [PW-1:0]   wr_ptr_reg;
    logic [PW-1:0]   rd_ptr_reg;
    logic [CW-1:0]   count_reg;
    logic            do_wr;
    logic            do_rd;

    assign full  = (count_reg == CW'(QDEPTH));
    assign empty = (count_reg == '0);
    assign count = count_reg;
    assign do_wr = wr_en && !full && !clr;
    assign do_rd = rd_en && !empty && !clr;

    // Head is read straight from storage so a popped entry reaches the
    // write port in the same cycle it is selected.
    assign dout = mem[rd_ptr_reg];

    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr_reg] <= din;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else if (clr) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_wr) begin
                wr_ptr_reg <= wr_ptr_reg + PW'(1);
            end
            if (do_rd) begin
                rd_ptr_reg <= rd_ptr_reg + PW'(1);
            end
            case ({do_wr, do_rd})
                2'b10:   count_reg <= count_reg + CW'(1);
                2'b01:   count_reg <= count_reg - CW'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/bp_update_ctrl.sv
// bp_update_ctrl -- write-port controller / arbiter for the BHT-BTB predictor.
// Detects direction and target mispredictions in E (combinational redirect),
// queues the needed table updates, and arbitrates the single predictor write
// port: invalidate sweep > configuration write > queued E update.
// Ports:
//   clk, RESET_N                 clock, asynchronous active-low reset
//   Branch_E, PC_E, PCSrc_E,
//   ALUResult_E                  resolved branch in E
//   PrPCSrc_E, PrALUResult_E     prediction carried from F
//   Flush_Req                    pulse: invalidate whole predictor
//   Cfg_Valid/PC/TA/Taken        configuration write request, Cfg_Ready accepts
//   Mispredict_E, Redirect_PC    combinational redirect to the front end
//   Stall_E                      update queue full, E must hold
//   Pred_Disable                 sweep in progress, ignore predictor output
//   Upd_PC, WE_PrPCSrc,
//   WE_PrALUResult, Upd_PCSrc,
//   Upd_ALUResult                predictor write port
// Optional feature: define BP_STATS_EN to add saturating Br_Count and
// Mispred_Count outputs.
module bp_update_ctrl
    import bp_pkg::*;
#(
    parameter int ENTRY_BITS = 4,
    parameter int QDEPTH     = 2
) (
    input  logic        clk,
    input  logic        RESET_N,
    input  logic        Branch_E,
    input  logic [31:0] PC_E,
    input  logic        PCSrc_E,
    input  logic [31:0] ALUResult_E,
    input  logic        PrPCSrc_E,
    input  logic [31:0] PrALUResult_E,
    input  logic        Flush_Req,
    input  logic        Cfg_Valid,
    input  logic [31:0] Cfg_PC,
    input  logic [31:0] Cfg_TA,
    input  logic        Cfg_Taken,
    output logic        Cfg_Ready,
    output logic        Mispredict_E,
    output logic [31:0] Redirect_PC,
    output logic        Stall_E,
    output logic        Pred_Disable,
    output logic [31:0] Upd_PC,
    output logic        WE_PrPCSrc,
    output logic        WE_PrALUResult,
    output logic        Upd_PCSrc,
    output logic [31:0] Upd_ALUResult
`ifdef BP_STATS_EN
    ,
    output logic [31:0] Br_Count,
    output logic [31:0] Mispred_Count
`endif
);

    localparam int ENTRIES = 2 ** ENTRY_BITS;

    bp_state_t               state_reg;
    bp_state_t               state_next;
    logic [ENTRY_BITS-1:0]   cnt_reg;
    logic [ENTRY_BITS-1:0]   cnt_next;

    logic                    dir_miss;
    logic                    tgt_miss;
    logic                    we_pb;
    logic                    we_ta;
    logic                    enq;
    logic                    q_pop;
    logic                    q_full;
    logic                    q_empty;
    logic [$clog2(QDEPTH):0] q_count;
    upd_entry_t              q_din;
    upd_entry_t              q_head;

    // ---------------- misprediction detection (0-cycle) ----------------
    assign dir_miss     = Branch_E && (PCSrc_E != PrPCSrc_E);
    assign tgt_miss     = Branch_E && PCSrc_E && PrPCSrc_E && (ALUResult_E != PrALUResult_E);
    assign Mispredict_E = dir_miss || tgt_miss;
    assign Redirect_PC  = PCSrc_E ? ALUResult_E : (PC_E + 32'd4);

    // A not-taken outcome never needs a target; only taken outcomes that
    // were missed in either way refresh the BTB entry.
    assign we_pb = dir_miss;
    assign we_ta = PCSrc_E && (dir_miss || tgt_miss);

    // Stall comes from the registered count, so a full queue stays stalled
    // even in a cycle where the head is being popped.
    assign Stall_E = q_full;
    assign enq     = Branch_E && !Stall_E && (state_reg == IDLE) && (we_pb || we_ta);

    assign q_din = '{pc: PC_E, ta: ALUResult_E, pcsrc: PCSrc_E, we_pb: we_pb, we_ta: we_ta};

    bp_upd_fifo #(
        .QDEPTH  (QDEPTH),
        .entry_t (upd_entry_t)
    ) u_fifo (
        .clk   (clk),
        .rst_n (RESET_N),
        .clr   (Flush_Req),
        .wr_en (enq),
        .rd_en (q_pop),
        .din   (q_din),
        .dout  (q_head),
        .count (q_count),
        .full  (q_full),
        .empty (q_empty)
    );

    // ---------------- FSM state register ----------------
    always_ff @(posedge clk or negedge RESET_N) begin
        if (!RESET_N) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    // ---------------- next state and write-port arbitration ----------------
    always_comb begin
        state_next     = state_reg;
        cnt_next       = cnt_reg;
        q_pop          = 1'b0;
        Cfg_Ready      = 1'b0;
        Pred_Disable   = 1'b0;
        Upd_PC         = '0;
        Upd_ALUResult  = '0;
        Upd_PCSrc      = 1'b0;
        WE_PrPCSrc     = 1'b0;
        WE_PrALUResult = 1'b0;

        case (state_reg)
            IDLE: begin
                Cfg_Ready = 1'b1;
                if (Flush_Req) begin
                    state_next = SWEEP;
                    cnt_next   = '0;
                end
                if (Cfg_Valid) begin
                    Upd_PC         = Cfg_PC;
                    Upd_ALUResult  = Cfg_TA;
                    Upd_PCSrc      = Cfg_Taken;
                    WE_PrPCSrc     = 1'b1;
                    WE_PrALUResult = 1'b1;
                end else if (!q_empty) begin
                    q_pop          = 1'b1;
                    Upd_PC         = q_head.pc;
                    Upd_ALUResult  = q_head.ta;
                    Upd_PCSrc      = q_head.pcsrc;
                    WE_PrPCSrc     = q_head.we_pb;
                    WE_PrALUResult = q_head.we_ta;
                end
            end

            SWEEP: begin
                Pred_Disable   = 1'b1;
                Upd_PC         = 32'({cnt_reg, {PRD_BITS{1'b0}}});
                WE_PrPCSrc     = 1'b1;
                WE_PrALUResult = 1'b1;
                if (Flush_Req) begin
                    cnt_next = '0;
                end else if (cnt_reg == ENTRY_BITS'(ENTRIES - 1)) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_reg + ENTRY_BITS'(1);
                end
            end

            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
    end

`ifdef BP_STATS_EN
    // Saturating event counters; a flush does not touch them.
    always_ff @(posedge clk or negedge RESET_N) begin
        if (!RESET_N) begin
            Br_Count      <= '0;
            Mispred_Count <= '0;
        end else begin
            if (Branch_E && !Stall_E && (Br_Count != 32'hFFFF_FFFF)) begin
                Br_Count <= Br_Count + 32'd1;
            end
            if (Mispredict_E && !Stall_E && (Mispred_Count != 32'hFFFF_FFFF)) begin
                Mispred_Count <= Mispred_Count + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_bp_update_ctrl.sv
// tb_bp_update_ctrl -- directed scoreboard bench for bp_update_ctrl.
// Stimulus pushes every expected predictor write into exp_q; a monitor on the
// falling edge pops and compares whenever a write enable is active, and checks
// the write port is quiet otherwise. Combinational outputs are checked inline.
module tb_bp_update_ctrl;

    logic        clk = 1'b0;
    logic        RESET_N;
    logic        Branch_E;
    logic [31:0] PC_E;
    logic        PCSrc_E;
    logic [31:0] ALUResult_E;
    logic        PrPCSrc_E;
    logic [31:0] PrALUResult_E;
    logic        Flush_Req;
    logic        Cfg_Valid;
    logic [31:0] Cfg_PC;
    logic [31:0] Cfg_TA;
    logic        Cfg_Taken;
    logic        Cfg_Ready;
    logic        Mispredict_E;
    logic [31:0] Redirect_PC;
    logic        Stall_E;
    logic        Pred_Disable;
    logic [31:0] Upd_PC;
    logic        WE_PrPCSrc;
    logic        WE_PrALUResult;
    logic        Upd_PCSrc;
    logic [31:0] Upd_ALUResult;
`ifdef BP_STATS_EN
    logic [31:0] Br_Count;
    logic [31:0] Mispred_Count;
`endif

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] ta;
        logic        pcsrc;
        logic        wpb;
        logic        wta;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   checks   = 0;
    int   failures = 0;

    bp_update_ctrl #(
        .ENTRY_BITS (4),
        .QDEPTH     (2)
    ) dut (
        .clk            (clk),
        .RESET_N        (RESET_N),
        .Branch_E       (Branch_E),
        .PC_E           (PC_E),
        .PCSrc_E        (PCSrc_E),
        .ALUResult_E    (ALUResult_E),
        .PrPCSrc_E      (PrPCSrc_E),
        .PrALUResult_E  (PrALUResult_E),
        .Flush_Req      (Flush_Req),
        .Cfg_Valid      (Cfg_Valid),
        .Cfg_PC         (Cfg_PC),
        .Cfg_TA         (Cfg_TA),
        .Cfg_Taken      (Cfg_Taken),
        .Cfg_Ready      (Cfg_Ready),
        .Mispredict_E   (Mispredict_E),
        .Redirect_PC    (Redirect_PC),
        .Stall_E        (Stall_E),
        .Pred_Disable   (Pred_Disable),
        .Upd_PC         (Upd_PC),
        .WE_PrPCSrc     (WE_PrPCSrc),
        .WE_PrALUResult (WE_PrALUResult),
        .Upd_PCSrc      (Upd_PCSrc),
        .Upd_ALUResult  (Upd_ALUResult)
`ifdef BP_STATS_EN
        ,
        .Br_Count       (Br_Count),
        .Mispred_Count  (Mispred_Count)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic push(input logic [31:0] pc, input logic [31:0] ta,
                        input logic pcsrc, input logic wpb, input logic wta);
        exp_t e;
        e.pc = pc; e.ta = ta; e.pcsrc = pcsrc; e.wpb = wpb; e.wta = wta;
        exp_q.push_back(e);
    endtask

    task automatic push_sweep(input int n);
        for (int i = 0; i < n; i++) begin
            push(32'(i * 4), 32'h0, 1'b0, 1'b1, 1'b1);
        end
    endtask

    task automatic br(input logic [31:0] pc, input logic t, input logic [31:0] ta,
                      input logic pt, input logic [31:0] pta);
        Branch_E = 1'b1; PC_E = pc; PCSrc_E = t; ALUResult_E = ta;
        PrPCSrc_E = pt; PrALUResult_E = pta;
    endtask

    task automatic br_off();
        Branch_E = 1'b0; PC_E = '0; PCSrc_E = 1'b0; ALUResult_E = '0;
        PrPCSrc_E = 1'b0; PrALUResult_E = '0;
    endtask

    // Write-port monitor: one line per observed write on a mismatch.
    always @(negedge clk) begin
        if (WE_PrPCSrc || WE_PrALUResult) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_write: got Upd_PC 0x%08h expected no write", Upd_PC);
            end else begin
                mon_e = exp_q.pop_front();
                chk("upd_pc",    Upd_PC,                 mon_e.pc);
                chk("upd_ta",    Upd_ALUResult,          mon_e.ta);
                chk("upd_pcsrc", 32'(Upd_PCSrc),         32'(mon_e.pcsrc));
                chk("we_pb",     32'(WE_PrPCSrc),        32'(mon_e.wpb));
                chk("we_ta",     32'(WE_PrALUResult),    32'(mon_e.wta));
            end
        end else begin
            chk("idle_upd_pc",    Upd_PC,         32'h0);
            chk("idle_upd_ta",    Upd_ALUResult,  32'h0);
            chk("idle_upd_pcsrc", 32'(Upd_PCSrc), 32'h0);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        RESET_N = 1'b0; Flush_Req = 1'b0;
        Cfg_Valid = 1'b0; Cfg_PC = '0; Cfg_TA = '0; Cfg_Taken = 1'b0;
        br_off();
        repeat (3) @(posedge clk);
        mid();
        chk("reset_stall",     32'(Stall_E),      32'h0);
        chk("reset_pred_dis",  32'(Pred_Disable), 32'h0);
        chk("reset_cfg_ready", 32'(Cfg_Ready),    32'h1);
        nxt(); RESET_N = 1'b1;
        mid();

        // Direction miss: predicted NT, taken to 0x100.
        nxt(); br(32'h40, 1'b1, 32'h100, 1'b0, 32'h0);
        push(32'h40, 32'h100, 1'b1, 1'b1, 1'b1);
        mid();
        chk("t1_mispredict", 32'(Mispredict_E), 32'h1);
        chk("t1_redirect",   Redirect_PC,       32'h100);
        chk("t1_no_write_same_cycle", 32'(WE_PrPCSrc), 32'h0);
        nxt(); br_off(); mid();
        chk("t1_write_next_cycle", 32'(WE_PrALUResult), 32'h1);

        // Target miss: predicted taken 0x100, actual 0x200.
        nxt(); br(32'h80, 1'b1, 32'h200, 1'b1, 32'h100);
        push(32'h80, 32'h200, 1'b1, 1'b0, 1'b1);
        mid();
        chk("t2_mispredict", 32'(Mispredict_E), 32'h1);
        chk("t2_redirect",   Redirect_PC,       32'h200);
        nxt(); br_off(); mid();

        // Correct prediction: nothing queued.
        nxt(); br(32'hC0, 1'b1, 32'h100, 1'b1, 32'h100);
        mid();
        chk("t3_mispredict", 32'(Mispredict_E), 32'h0);
        chk("t3_redirect",   Redirect_PC,       32'h100);
        nxt(); br_off(); mid();
        chk("t3_no_write", 32'(WE_PrALUResult), 32'h0);

        // Predicted taken, resolved not taken: PHT-only write.
        nxt(); br(32'h44, 1'b0, 32'h55, 1'b1, 32'h100);
        push(32'h44, 32'h55, 1'b0, 1'b1, 1'b0);
        mid();
        chk("t4_mispredict", 32'(Mispredict_E), 32'h1);
        chk("t4_redirect",   Redirect_PC,       32'h48);
        nxt(); br_off(); PCSrc_E = 1'b1; ALUResult_E = 32'h77; mid();
        chk("t4_nobranch_mispredict", 32'(Mispredict_E), 32'h0);
        nxt(); br_off(); mid();

        // Cfg held 4 cycles while 3 mispredicting branches arrive.
        nxt();
        Cfg_Valid = 1'b1; Cfg_PC = 32'h10; Cfg_TA = 32'h300; Cfg_Taken = 1'b1;
        for (int i = 0; i < 4; i++) push(32'h10, 32'h300, 1'b1, 1'b1, 1'b1);
        br(32'h200, 1'b1, 32'h400, 1'b0, 32'h0);
        push(32'h200, 32'h400, 1'b1, 1'b1, 1'b1);
        mid(); chk("t5_stall_c0", 32'(Stall_E), 32'h0);
        chk("t5_cfg_ready", 32'(Cfg_Ready), 32'h1);
        nxt(); br(32'h204, 1'b1, 32'h404, 1'b0, 32'h0);
        push(32'h204, 32'h404, 1'b1, 1'b1, 1'b1);
        mid(); chk("t5_stall_c1", 32'(Stall_E), 32'h0);
        nxt(); br(32'h208, 1'b1, 32'h408, 1'b0, 32'h0);
        push(32'h208, 32'h408, 1'b1, 1'b1, 1'b1);
        mid(); chk("t5_stall_c2", 32'(Stall_E), 32'h1);
        nxt(); mid(); chk("t5_stall_c3", 32'(Stall_E), 32'h1);
        nxt(); Cfg_Valid = 1'b0; mid(); chk("t5_stall_pop_full", 32'(Stall_E), 32'h1);
        nxt(); mid(); chk("t5_stall_c5", 32'(Stall_E), 32'h0);
        nxt(); br_off(); mid();
        nxt(); mid(); chk("t5_drained", 32'(exp_q.size()), 32'h0);

        // Flush with two queued updates, then a full 16-entry sweep.
        nxt(); Cfg_Valid = 1'b1;
        for (int i = 0; i < 3; i++) push(32'h10, 32'h300, 1'b1, 1'b1, 1'b1);
        br(32'h300, 1'b1, 32'h500, 1'b0, 32'h0);
        mid();
        nxt(); br(32'h304, 1'b1, 32'h504, 1'b0, 32'h0); mid();
        nxt(); br_off(); Flush_Req = 1'b1; push_sweep(16); mid();
        chk("t6_stall_before_flush", 32'(Stall_E),      32'h1);
        chk("t6_pd_flush_cycle",     32'(Pred_Disable), 32'h0);
        nxt(); Flush_Req = 1'b0; Cfg_Valid = 1'b0;
        br(32'h400, 1'b1, 32'h600, 1'b0, 32'h0);
        mid();
        chk("t6_queue_cleared",   32'(Stall_E),      32'h0);
        chk("t6_mispredict_sweep", 32'(Mispredict_E), 32'h1);
        chk("t6_pd_first",        32'(Pred_Disable), 32'h1);
        chk("t6_cfg_ready_first", 32'(Cfg_Ready),    32'h0);
        for (int i = 1; i < 16; i++) begin
            nxt(); br_off(); mid();
            chk("t6_pd_sweep",        32'(Pred_Disable), 32'h1);
            chk("t6_cfg_ready_sweep", 32'(Cfg_Ready),    32'h0);
        end
        nxt(); mid();
        chk("t6_pd_after",    32'(Pred_Disable), 32'h0);
        chk("t6_cfg_ready_after", 32'(Cfg_Ready), 32'h1);
        chk("t6_all_written", 32'(exp_q.size()), 32'h0);

        // Second flush at sweep cycle 5 restarts the index at 0.
        nxt(); Flush_Req = 1'b1; push_sweep(6); push_sweep(16); mid();
        nxt(); Flush_Req = 1'b0; mid();
        for (int i = 0; i < 4; i++) begin
            nxt(); mid();
        end
        nxt(); Flush_Req = 1'b1; mid();
        chk("t7_pc_at_refush", Upd_PC, 32'h14);
        nxt(); Flush_Req = 1'b0; mid();
        chk("t7_restart_pc", Upd_PC, 32'h0);
        for (int i = 1; i < 16; i++) begin
            nxt(); mid();
        end
        nxt(); mid();
        chk("t7_pd_after", 32'(Pred_Disable), 32'h0);
        chk("t7_all_written", 32'(exp_q.size()), 32'h0);

        // Reset mid-sweep: outputs return to reset values immediately.
        nxt(); Flush_Req = 1'b1; push_sweep(3); mid();
        nxt(); Flush_Req = 1'b0; mid();
        nxt(); mid();
        nxt(); mid();
        nxt(); RESET_N = 1'b0; mid();
        chk("t8_pd_reset",        32'(Pred_Disable),   32'h0);
        chk("t8_cfg_ready_reset", 32'(Cfg_Ready),      32'h1);
        chk("t8_stall_reset",     32'(Stall_E),        32'h0);
        chk("t8_we_reset",        32'(WE_PrALUResult), 32'h0);
        nxt(); RESET_N = 1'b1; mid();
        nxt(); mid();
        chk("t8_pd_after_reset", 32'(Pred_Disable), 32'h0);
        chk("t8_all_written",    32'(exp_q.size()), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
